// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-channel TDM receive path.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int NSLOT  = 4;
  localparam int SLOT_W = 2;

endpackage

// File: rtl/tdm_slot_dec.sv
// Combinational 2-to-4 one-hot slot decoder, gated by the slot strobe.
module tdm_slot_dec
  import tdm_pkg::*;
(
  input  logic              en,
  input  logic [SLOT_W-1:0] slot,
  output logic [NSLOT-1:0]  sel
);

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_dec
      assign sel[gi] = en && (slot == SLOT_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/tdm_demux_rx.sv
// TDM receive demux: frame-sync alignment with flywheel, slot steering, frame output.
// Optional TDM_RX_PARITY_EN adds P input and PAR_ERR pulse (even parity over frame + P).
module tdm_demux_rx
  import tdm_pkg::*;
#(
  parameter int W        = 8,
  parameter int MISS_MAX = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              FS,
  input  logic [W-1:0]      D,
  output logic [4*W-1:0]    O,
  output logic [SLOT_W-1:0] SLOT,
  output logic              LOCK,
  output logic              FRAME_VALID,
  output logic              SYNC_ERR
`ifdef TDM_RX_PARITY_EN
  , input  logic            P
  , output logic            PAR_ERR
`endif
);

  localparam logic [3:0] MISS_LIM = 4'(MISS_MAX);

  state_t            state_reg, state_next;
  logic [SLOT_W-1:0] slot_reg, slot_next;
  logic [3:0]        miss_reg, miss_next, miss_inc;
  logic [W-1:0]      shadow_reg [0:NSLOT-2];
  logic [4*W-1:0]    o_reg;
  logic              fv_reg, serr_reg, serr_next;
  logic [NSLOT-2:0]  sh_we;
  logic              frame_done;
  logic [NSLOT-1:0]  sel;

  tdm_slot_dec u_slot_dec (
    .en   (EN),
    .slot (slot_reg),
    .sel  (sel)
  );

  assign miss_inc = miss_reg + 4'd1;

  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    miss_next  = miss_reg;
    sh_we      = '0;
    frame_done = 1'b0;
    serr_next  = 1'b0;
    case (state_reg)
      HUNT: begin
        if (EN && FS) begin
          sh_we[0]   = 1'b1;
          slot_next  = 2'd1;
          state_next = LOCKED;
          miss_next  = '0;
        end
      end
      LOCKED: begin
        if (EN && FS) begin
          // Sync on any slot realigns; off-slot-0 sync drops the partial frame.
          serr_next = (slot_reg != '0);
          sh_we[0]  = 1'b1;
          slot_next = 2'd1;
          miss_next = '0;
        end else if (sel[3]) begin
          frame_done = 1'b1;
          slot_next  = '0;
        end else if (sel[0]) begin
          // Flywheel: keep receiving on a missing sync until MISS_MAX in a row.
          if (miss_inc == MISS_LIM) begin
            state_next = HUNT;
            slot_next  = '0;
            miss_next  = '0;
          end else begin
            miss_next = miss_inc;
            sh_we[0]  = 1'b1;
            slot_next = 2'd1;
          end
        end else if (sel[2:1] != '0) begin
          sh_we     = sel[2:0];
          slot_next = slot_reg + 2'd1;
        end
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= HUNT;
      slot_reg  <= '0;
      miss_reg  <= '0;
      o_reg     <= '0;
      fv_reg    <= 1'b0;
      serr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
      miss_reg  <= miss_next;
      fv_reg    <= frame_done;
      serr_reg  <= serr_next;
      if (frame_done)
        o_reg <= {D, shadow_reg[2], shadow_reg[1], shadow_reg[0]};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT - 1; gi++) begin : g_shadow
      always_ff @(posedge CLK) begin
        if (RST)
          shadow_reg[gi] <= '0;
        else if (sh_we[gi])
          shadow_reg[gi] <= D;
      end
    end
  endgenerate

`ifdef TDM_RX_PARITY_EN
  logic par_err_reg;
  logic frame_par;

  assign frame_par = ^{D, shadow_reg[2], shadow_reg[1], shadow_reg[0], P};

  always_ff @(posedge CLK) begin
    if (RST)
      par_err_reg <= 1'b0;
    else
      par_err_reg <= frame_done && frame_par;
  end

  assign PAR_ERR = par_err_reg;
`endif

  assign O           = o_reg;
  assign SLOT        = slot_reg;
  assign LOCK        = (state_reg == LOCKED);
  assign FRAME_VALID = fv_reg;
  assign SYNC_ERR    = serr_reg;

endmodule

// File: doc/tdm_demux_rx.md
Name: tdm_demux_rx

Overview:
Receive end of the 4-channel time-division link. The transmit end drives a W-bit bus through the 4:1 MUX under a free-running 2-bit slot select. This block recovers frame alignment from a frame-sync strobe, steers each slot into its channel register (DEMUX function, registered), and presents a complete 4-channel frame with a one-cycle valid pulse. It sits between the shared TDM bus and the per-channel consumers.

Parameters:
W, 8, data width of one slot/channel
MISS_MAX, 3, consecutive missing FS at expected slot 0 before loss of lock (1..15)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous, active-high reset
EN  input  1  slot strobe; D/FS/P sampled only when EN=1
FS  input  1  frame sync, marks the beat carrying slot 0
D  input  W  slot data
O  output  4*W  frame output; O[W*k+W-1:W*k] = channel k
SLOT  output  2  slot index expected on next EN beat
LOCK  output  1  1 while in LOCKED state
FRAME_VALID  output  1  one-cycle pulse, O just updated with a complete frame
SYNC_ERR  output  1  one-cycle pulse, FS seen at slot != 0 while locked

Behaviour:
- Single clock; reset synchronous active-high. RST dominates every other input.
- Reset values: state=HUNT, SLOT=0, miss counter=0, shadow regs=0, O=0, LOCK=0, FRAME_VALID=0, SYNC_ERR=0 (PAR_ERR=0 if compiled in).
- FRAME_VALID, SYNC_ERR and PAR_ERR are pulses: they deassert on every cycle not generating them, including EN=0 cycles.
- EN=0: state, SLOT, shadow, O and miss counter hold.
- Storage: shadow[0..2] hold slots 0-2 of the current frame. Slot 3 is never shadowed.
- HUNT, EN=1, FS=1: shadow[0]<=D, SLOT<=1, state<=LOCKED, miss<=0. LOCK=1 from the next cycle.
- HUNT, EN=1, FS=0: beat discarded, nothing changes.
- LOCKED, EN=1, SLOT=k, FS=0, k in 1..2: shadow[k]<=D, SLOT<=k+1.
- LOCKED, EN=1, SLOT=3, FS=0: O<={D, shadow[2], shadow[1], shadow[0]}, FRAME_VALID<=1, SLOT<=0 (wrap). Latency: O and FRAME_VALID are visible the cycle after the slot-3 beat.
- LOCKED, EN=1, SLOT=0, FS=1: shadow[0]<=D, SLOT<=1, miss<=0.
- LOCKED, EN=1, SLOT=0, FS=0 (flywheel):
  - miss<=miss+1.
  - If miss+1==MISS_MAX: state<=HUNT, SLOT<=0, miss<=0, beat discarded.
  - Otherwise shadow[0]<=D, SLOT<=1.
- LOCKED, EN=1, FS=1, SLOT!=0 (early sync): SYNC_ERR<=1, the partial frame is dropped (no FRAME_VALID), beat treated as slot 0: shadow[0]<=D, SLOT<=1, miss<=0. This rule has priority over the slot-3 completion rule.
- O holds its last complete frame through HUNT and loss of lock; only RST clears it.
- SLOT width is fixed at 2; the increment wraps 3->0 naturally.

Optional Feature:
TDM_RX_PARITY_EN
- Defined:
  - Adds input P (1 bit), sampled on the slot-3 beat.
  - Adds output PAR_ERR (1 bit), pulsed together with FRAME_VALID when the XOR of all 4*W frame bits and P is 1 (even parity).
  - O still updates on a parity error.
- Undefined: no P or PAR_ERR ports, no parity logic.

Decomposition:
- Shared package tdm_pkg:
  - state enum {HUNT, LOCKED}
  - constant NSLOT=4
  - constant SLOT_W=2
- One natural sub-module: tdm_slot_dec, a combinational 2-to-4 one-hot decoder of SLOT gated by EN. Its output drives the shadow write enables.

Test Plan:
- RST, then EN=1 each cycle, FS=1 with D=0x11, then D=0x22,0x33,0x44 -> next cycle O=0x44332211, FRAME_VALID=1 for exactly one cycle; LOCK=1 from the cycle after the first beat; SLOT sequence 0,1,2,3,0.
- Same frame with EN=1 only every third cycle -> identical O=0x44332211; SLOT and O hold on EN=0 cycles; one FRAME_VALID pulse.
- Locked, FS=1 on the slot-2 beat with D=0xAA -> SYNC_ERR one cycle, no FRAME_VALID. The next three beats 0xBB,0xCC,0xDD complete a frame -> O=0xDDCCBBAA.
- MISS_MAX=3, locked, three frames with FS held 0:
  - first two frames still produce FRAME_VALID;
  - third slot-0 beat -> LOCK=0, SLOT=0, no further FRAME_VALID until FS=1;
  - O retains the last frame.
- RST=1 asserted at SLOT=2 -> next cycle O=0, SLOT=0, LOCK=0, all pulses 0; data beats with FS=0 ignored afterwards.
- With TDM_RX_PARITY_EN, frame 0x00000001 with P=0 -> PAR_ERR=1 with FRAME_VALID; same frame with P=1 -> PAR_ERR=0.
